alu_arbiter: RTL and testbench

//  Shares one instance of the team's combinational ALU (`alu`, whose set-less-than flag is derived from

---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu.sv | 48 ++++
 rtl/alu_arbiter_rr_pick2.sv | 20 ++
 rtl/alu_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter: FSM encoding and ALU opcodes.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;
  localparam logic [4:0] ALU_SRL = 5'b00110;
  localparam logic [4:0] ALU_SRA = 5'b00111;

endpackage

// File: rtl/alu.sv
// Combinational ALU. The set-less-than flag always comes from A-B: result sign
// corrected by the signed-subtract overflow, independent of the selected opcode.
module alu
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int SHAMT_W = 5
) (
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  output logic [DATA_W-1:0]  result,
  output logic               lt,
  output logic               ne,
  output logic               ovf
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;

  // Result mux plus comparison/overflow flags.
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    lt      = diff[DATA_W-1] ^ sub_ovf;
    ne      = (a != b);
    result  = '0;
    ovf     = 1'b0;
    case (op)
      ALU_ADD: begin result = sum;  ovf = add_ovf; end
      ALU_SUB: begin result = diff; ovf = sub_ovf; end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      default: begin result = '0; ovf = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to ptr.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       grant_id,
  output logic       grant_any
);

  // Winner selection.
  always_comb begin
    grant_any = |valid;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ptr;
      default: grant_id = ptr;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, one op per 3 cycles.
// Optional per-requester saturating grant counters under ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 5,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
`ifdef ALU_ARB_STATS_EN
  output logic [CNT_W-1:0]   grant_cnt_0,
  output logic [CNT_W-1:0]   grant_cnt_1,
`endif
  input  logic               req_valid_0,
  output logic               req_ready_0,
  input  logic [OP_W-1:0]    req_op_0,
  input  logic [SHAMT_W-1:0] req_shamt_0,
  input  logic [DATA_W-1:0]  req_a_0,
  input  logic [DATA_W-1:0]  req_b_0,
  output logic               resp_valid_0,
  input  logic               resp_ready_0,
  output logic [DATA_W-1:0]  resp_result_0,
  output logic               resp_lt_0,
  output logic               resp_ne_0,
  output logic               resp_ovf_0,
  input  logic               req_valid_1,
  output logic               req_ready_1,
  input  logic [OP_W-1:0]    req_op_1,
  input  logic [SHAMT_W-1:0] req_shamt_1,
  input  logic [DATA_W-1:0]  req_a_1,
  input  logic [DATA_W-1:0]  req_b_1,
  output logic               resp_valid_1,
  input  logic               resp_ready_1,
  output logic [DATA_W-1:0]  resp_result_1,
  output logic               resp_lt_1,
  output logic               resp_ne_1,
  output logic               resp_ovf_1
);

  arb_state_e             state_q, state_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic                   gid_q, gid_d;
  logic [OP_W-1:0]        op_q, op_d;
  logic [SHAMT_W-1:0]     shamt_q, shamt_d;
  logic [DATA_W-1:0]      a_q, a_d;
  logic [DATA_W-1:0]      b_q, b_d;
  logic [1:0][DATA_W-1:0] res_q, res_d;
  logic [1:0]             lt_q, lt_d;
  logic [1:0]             ne_q, ne_d;
  logic [1:0]             ovf_q, ovf_d;

  logic [1:0]             req_valid_s;
  logic [1:0]             req_ready_s;
  logic                   pick_id;
  logic                   pick_any;
  logic                   resp_sel_ready;
  logic [DATA_W-1:0]      alu_result;
  logic                   alu_lt;
  logic                   alu_ne;
  logic                   alu_ovf;

  assign req_valid_s    = {req_valid_1, req_valid_0};
  assign resp_sel_ready = gid_q ? resp_ready_1 : resp_ready_0;

  rr_pick2 u_pick (
    .valid     (req_valid_s),
    .ptr       (rr_ptr_q),
    .grant_id  (pick_id),
    .grant_any (pick_any)
  );

  alu #(
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .op     (op_q),
    .shamt  (shamt_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .lt     (alu_lt),
    .ne     (alu_ne),
    .ovf    (alu_ovf)
  );

  // Next-state, grant latch and response capture.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    op_d        = op_q;
    shamt_d     = shamt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    lt_d        = lt_q;
    ne_d        = ne_q;
    ovf_d       = ovf_q;
    req_ready_s = 2'b00;
    case (state_q)
      IDLE: begin
        // reset_n gating keeps req_ready low while reset is held.
        if (pick_any && reset_n) begin
          req_ready_s[pick_id] = 1'b1;
          gid_d                = pick_id;
          if (pick_id) begin
            op_d    = req_op_1;
            shamt_d = req_shamt_1;
            a_d     = req_a_1;
            b_d     = req_b_1;
          end else begin
            op_d    = req_op_0;
            shamt_d = req_shamt_0;
            a_d     = req_a_0;
            b_d     = req_b_0;
          end
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_d[gid_q] = alu_result;
        lt_d[gid_q]  = alu_lt;
        ne_d[gid_q]  = alu_ne;
        ovf_d[gid_q] = alu_ovf;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_sel_ready) begin
          state_d  = IDLE;
          rr_ptr_d = ~gid_q;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      gid_q    <= 1'b0;
      op_q     <= '0;
      shamt_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      lt_q     <= 2'b00;
      ne_q     <= 2'b00;
      ovf_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      lt_q     <= lt_d;
      ne_q     <= ne_d;
      ovf_q    <= ovf_d;
    end
  end

  assign req_ready_0   = req_ready_s[0];
  assign req_ready_1   = req_ready_s[1];
  assign resp_valid_0  = (state_q == RESP) && !gid_q;
  assign resp_valid_1  = (state_q == RESP) &&  gid_q;
  assign resp_result_0 = res_q[0];
  assign resp_result_1 = res_q[1];
  assign resp_lt_0     = lt_q[0];
  assign resp_lt_1     = lt_q[1];
  assign resp_ne_0     = ne_q[0];
  assign resp_ne_1     = ne_q[1];
  assign resp_ovf_0    = ovf_q[0];
  assign resp_ovf_1    = ovf_q[1];

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Saturating accept counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (req_valid_s[k] && req_ready_s[k] && (cnt_q[k] != CNT_MAX)) begin
        cnt_d[k] = cnt_q[k] + CNT_ONE;
      end else begin
        cnt_d[k] = cnt_q[k];
      end
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_0 = cnt_q[0];
  assign grant_cnt_1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter; grant-counter checks compile in with ALU_ARB_STATS_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  typedef struct {
    bit          id;
    logic [31:0] res;
    logic        lt;
    logic        ne;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [4:0]  req_op_0 = 5'd0, req_op_1 = 5'd0;
  logic [4:0]  req_shamt_0 = 5'd0, req_shamt_1 = 5'd0;
  logic [31:0] req_a_0 = 32'd0, req_a_1 = 32'd0, req_b_0 = 32'd0, req_b_1 = 32'd0;
  logic        resp_valid_0, resp_valid_1;
  logic        resp_ready_0 = 1'b1, resp_ready_1 = 1'b1;
  logic [31:0] resp_result_0, resp_result_1;
  logic        resp_lt_0, resp_lt_1, resp_ne_0, resp_ne_1, resp_ovf_0, resp_ovf_1;
`ifdef ALU_ARB_STATS_EN
  logic [1:0]  grant_cnt_0, grant_cnt_1;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  alu_arbiter #(
    .DATA_W(32), .OP_W(5), .SHAMT_W(5),
`ifdef ALU_ARB_STATS_EN
    .CNT_W(2)
`else
    .CNT_W(16)
`endif
  ) dut (
    .clock(clock), .reset_n(reset_n),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1),
`endif
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_op_0(req_op_0),
    .req_shamt_0(req_shamt_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0), .resp_result_0(resp_result_0),
    .resp_lt_0(resp_lt_0), .resp_ne_0(resp_ne_0), .resp_ovf_0(resp_ovf_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_op_1(req_op_1),
    .req_shamt_1(req_shamt_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1), .resp_result_1(resp_result_1),
    .resp_lt_1(resp_lt_1), .resp_ne_1(resp_ne_1), .resp_ovf_1(resp_ovf_1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit id, input logic [31:0] r, input logic lt,
                              input logic ne, input logic ovf);
    exp_t e;
    e.id = id; e.res = r; e.lt = lt; e.ne = ne; e.ovf = ovf;
    return e;
  endfunction

  task automatic mon_one(input bit k, input logic [31:0] r, input logic lt,
                         input logic ne, input logic ovf);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_resp channel=%0d result=0x%08h at %0t", k, r, $time);
    end else begin
      e = sb.pop_front();
      chk("resp_id", {31'd0, k}, {31'd0, e.id});
      chk("resp_result", r, e.res);
      chk("resp_flags", {29'd0, lt, ne, ovf}, {29'd0, e.lt, e.ne, e.ovf});
    end
  endtask

  // Monitor: pop and compare on every response handshake.
  always @(negedge clock) begin
    if (reset_n) begin
      if (resp_valid_0 && resp_ready_0) mon_one(1'b0, resp_result_0, resp_lt_0, resp_ne_0, resp_ovf_0);
      if (resp_valid_1 && resp_ready_1) mon_one(1'b1, resp_result_1, resp_lt_1, resp_ne_1, resp_ovf_1);
    end
  end

  task automatic drive(input bit k, input logic v, input logic [4:0] op, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
    if (k) begin
      req_valid_1 = v; req_op_1 = op; req_shamt_1 = sh; req_a_1 = a; req_b_1 = b;
    end else begin
      req_valid_0 = v; req_op_0 = op; req_shamt_0 = sh; req_a_0 = a; req_b_0 = b;
    end
  endtask

  task automatic wait_accept(input bit k);
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (k ? req_ready_1 : req_ready_0) begin
        got = 1'b1;
        break;
      end
    end
    chk(k ? "accept_1" : "accept_0", {31'd0, got}, 32'd1);
  endtask

  task automatic send(input bit k, input logic [4:0] op, input logic [4:0] sh,
                      input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(posedge clock); #1;
    sb.push_back(e);
    drive(k, 1'b1, op, sh, a, b);
    wait_accept(k);
    @(posedge clock); #1;
    if (k) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    chk(name, sb.size(), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Both requesters held valid for n accepts; grants must alternate starting at 0.
  task automatic both_valid(input int n, input string name);
    int acc = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) sb.push_back(mk(1'b0, 32'h0000_0007, 1'b1, 1'b1, 1'b0));
      else            sb.push_back(mk(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0));
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b1, ALU_ADD, 5'd0, 32'd3, 32'd4);
    drive(1'b1, 1'b1, ALU_XOR, 5'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    for (int c = 0; c < 20 * n && acc < n; c++) begin
      @(negedge clock);
      if (req_ready_0 || req_ready_1) begin
        chk(name, {30'd0, req_ready_1, req_ready_0}, (acc % 2 == 0) ? 32'd1 : 32'd2);
        acc++;
      end
    end
    chk({name, "_count"}, acc, n);
    @(posedge clock); #1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with a request already pending.
    req_valid_0 = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", {30'd0, req_ready_1, req_ready_0}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    chk("rst_result_0", resp_result_0, 32'd0);
    chk("rst_flags", {26'd0, resp_lt_0, resp_ne_0, resp_ovf_0, resp_lt_1, resp_ne_1, resp_ovf_1}, 32'd0);
    req_valid_0 = 1'b0;
    reset_n = 1'b1;

    // 1: SUB 5-7 on requester 0 with latency check.
    @(posedge clock); #1;
    sb.push_back(mk(1'b0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0));
    drive(1'b0, 1'b1, ALU_SUB, 5'd0, 32'd5, 32'd7);
    @(negedge clock);
    chk("t1_accept", {31'd0, req_ready_0}, 32'd1);
    @(posedge clock); #1;
    req_valid_0 = 1'b0;
    @(negedge clock);
    chk("t1_valid_n1", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    @(negedge clock);
    chk("t1_valid_n2", {30'd0, resp_valid_1, resp_valid_0}, 32'd1);
    drain("t1_drain");

    // 2: arbitration from reset alternates 0,1,0,1.
    pulse_reset();
    both_valid(4, "t2_grant");
    drain("t2_drain");

    // 3 and boundary operands.
    send(1'b1, ALU_SUB, 5'd0, 32'h8000_0000, 32'd1, mk(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1));
    send(1'b0, ALU_ADD, 5'd0, 32'h7FFF_FFFF, 32'd1, mk(1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1));
    send(1'b1, ALU_SRA, 5'd4, 32'h8000_0000, 32'd0, mk(1'b1, 32'hF800_0000, 1'b1, 1'b1, 1'b0));
    send(1'b0, ALU_SUB, 5'd0, 32'd9, 32'd9, mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0));
    drain("t3_drain");

    // 5: reset during EXEC drops the op and returns rr_ptr to 0.
    @(posedge clock); #1;
    drive(1'b1, 1'b1, ALU_ADD, 5'd0, 32'd1, 32'd1);
    wait_accept(1'b1);
    @(posedge clock); #1;
    req_valid_1 = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    chk("t5_rst_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("t5_no_resp", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);
    end
    both_valid(2, "t5_grant");
    drain("t5_drain");

    // 4: response backpressure on channel 0 while requester 1 waits.
    resp_ready_0 = 1'b0;
    send(1'b0, ALU_AND, 5'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, mk(1'b0, 32'h0F00_0F00, 1'b1, 1'b1, 1'b0));
    sb.push_back(mk(1'b1, 32'd30, 1'b1, 1'b1, 1'b0));
    drive(1'b1, 1'b1, ALU_ADD, 5'd0, 32'd10, 32'd20);
    for (int i = 0; i < 10; i++) begin
      if (!resp_valid_0) @(negedge clock);
    end
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd1);
      chk("t4_stall_result", resp_result_0, 32'h0F00_0F00);
      chk("t4_stall_ready1", {31'd0, req_ready_1}, 32'd0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    resp_ready_0 = 1'b1;
    @(negedge clock);
    chk("t4_release_ready1", {31'd0, req_ready_1}, 32'd0);
    @(negedge clock);
    chk("t4_grant1", {31'd0, req_ready_1}, 32'd1);
    @(posedge clock); #1;
    req_valid_1 = 1'b0;
    drain("t4_drain");
    @(negedge clock);
    chk("t4_hold_result_0", resp_result_0, 32'h0F00_0F00);
    chk("t4_hold_valid", {30'd0, resp_valid_1, resp_valid_0}, 32'd0);

`ifdef ALU_ARB_STATS_EN
    // 6: saturating grant counters.
    pulse_reset();
    chk("t6_cnt_rst", {28'd0, grant_cnt_1, grant_cnt_0}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(1'b0, ALU_ADD, 5'd0, 32'd0, 32'd0, mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b0));
    end
    drain("t6_drain0");
    chk("t6_cnt0_sat", {30'd0, grant_cnt_0}, 32'd3);
    chk("t6_cnt1_idle", {30'd0, grant_cnt_1}, 32'd0);
    send(1'b1, ALU_ADD, 5'd0, 32'd0, 32'd0, mk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0));
    drain("t6_drain1");
    chk("t6_cnt1_one", {30'd0, grant_cnt_1}, 32'd1);
    chk("t6_cnt0_hold", {30'd0, grant_cnt_0}, 32'd3);
`endif

    repeat (3) @(negedge clock);
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
